// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - packs decoded RISC-V fields into instruction words and writes them to memory
//
// Purpose: inverse of the core's immediate generator. Each accepted field set
// is encoded (I/S/B/R formats), range-checked, and either written to the next
// sequential word of instruction memory or reported as an error.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   clear               synchronous restart of address and word count
//   in_valid/in_ready   field-set handshake (in_ready = !full && !clear)
//   opcode..imm         decoded fields and sign-extended immediate
//   mem_we/addr/wdata   registered one-cycle memory write
//   err_valid/err_code  registered one-cycle error pulse (01 opcode, 10 range, 11 B misaligned)
//   word_count, full    number of words written, and word_count == DEPTH
module instr_encoder_loader #(
  parameter int ADDR_W    = 10,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              err_valid,
  output logic [1:0]        err_code,
  output logic [CW-1:0]     word_count,
  output logic              full
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_OPCODE = 2'b01;
  localparam logic [1:0] ERR_RANGE  = 2'b10;
  localparam logic [1:0] ERR_ALIGN  = 2'b11;

  localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(4);
  localparam logic [CW-1:0]     LAST   = CW'(DEPTH - 1);

  logic [ADDR_W-1:0] next_addr;
  logic              accept;
  logic [31:0]       packed_word;
  logic [1:0]        enc_err;
  logic              fits12;
  logic              fits13;

  assign in_ready = !full && !clear;
  assign accept   = in_valid && in_ready;

  // A 12-bit signed field holds imm only if bits 31..11 are a pure sign
  // extension; the 13-bit branch offset likewise needs bits 31..12.
  assign fits12 = (&imm[31:11]) || !(|imm[31:11]);
  assign fits13 = (&imm[31:12]) || !(|imm[31:12]);

  always_comb begin
    packed_word = 32'd0;
    enc_err     = ERR_NONE;
    case (opcode)
      OP_LOAD, OP_IMM: begin
        packed_word = {imm[11:0], rs1, funct3, rd, opcode};
        if (!fits12) enc_err = ERR_RANGE;
      end
      OP_STORE: begin
        packed_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        if (!fits12) enc_err = ERR_RANGE;
      end
      OP_BRANCH: begin
        packed_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        // Range error takes precedence over misalignment.
        if (!fits13)     enc_err = ERR_RANGE;
        else if (imm[0]) enc_err = ERR_ALIGN;
      end
      OP_REG: begin
        packed_word = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      default: enc_err = ERR_OPCODE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we     <= 1'b0;
      mem_addr   <= BASE;
      mem_wdata  <= 32'd0;
      err_valid  <= 1'b0;
      err_code   <= ERR_NONE;
      word_count <= '0;
      full       <= 1'b0;
      next_addr  <= BASE;
    end else begin
      mem_we    <= 1'b0;
      err_valid <= 1'b0;
      if (clear) begin
        next_addr  <= BASE;
        word_count <= '0;
        full       <= 1'b0;
      end else if (accept) begin
        if (enc_err == ERR_NONE) begin
          mem_we     <= 1'b1;
          mem_addr   <= next_addr;
          mem_wdata  <= packed_word;
          next_addr  <= next_addr + STRIDE;
          word_count <= word_count + 1'b1;
          // full rises alongside the DEPTH-th strobe, not one cycle later.
          full       <= (word_count == LAST);
        end else begin
          err_valid <= 1'b1;
          err_code  <= enc_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - directed self-checking bench for instr_encoder_loader
module tb_instr_encoder_loader;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              clear = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [6:0]        opcode = '0;
  logic [4:0]        rd = '0;
  logic [4:0]        rs1 = '0;
  logic [4:0]        rs2 = '0;
  logic [2:0]        funct3 = '0;
  logic [6:0]        funct7 = '0;
  logic [31:0]       imm = '0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              err_valid;
  logic [1:0]        err_code;
  logic [CW-1:0]     word_count;
  logic              full;

  int vectors = 0;
  int miscompares = 0;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .err_valid(err_valid), .err_code(err_code),
    .word_count(word_count), .full(full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one field set and advance to the next falling edge, where the
  // registered result of that edge is visible. in_valid stays high so
  // consecutive calls are back-to-back accepts.
  task automatic drive(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] im);
    opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_err", 32'(err_valid), 32'd0);
    check("rst_code", 32'(err_code), 32'd0);
    check("rst_count", 32'(word_count), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd1);

    // lw x5,8(x2)
    drive(7'b0000011, 5'd5, 5'd2, 5'd0, 3'b010, 7'd0, 32'd8);
    check("lw_we", 32'(mem_we), 32'd1);
    check("lw_addr", 32'(mem_addr), 32'd0);
    check("lw_wdata", mem_wdata, 32'h00812283);
    check("lw_count", 32'(word_count), 32'd1);

    // sw x5,-4(x2), back-to-back
    drive(7'b0100011, 5'd0, 5'd2, 5'd5, 3'b010, 7'd0, 32'hFFFFFFFC);
    check("sw_we", 32'(mem_we), 32'd1);
    check("sw_addr", 32'(mem_addr), 32'd4);
    check("sw_wdata", mem_wdata, 32'hFE512E23);
    check("sw_count", 32'(word_count), 32'd2);

    // beq x1,x2,-8
    drive(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'hFFFFFFF8);
    check("beq_addr", 32'(mem_addr), 32'd8);
    check("beq_wdata", mem_wdata, 32'hFE208CE3);
    check("beq_count", 32'(word_count), 32'd3);

    // beq with odd offset -> misaligned
    drive(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd5);
    check("bmis_err", 32'(err_valid), 32'd1);
    check("bmis_code", 32'(err_code), 32'd3);
    check("bmis_we", 32'(mem_we), 32'd0);
    check("bmis_wdata_hold", mem_wdata, 32'hFE208CE3);
    check("bmis_count", 32'(word_count), 32'd3);

    // addi with imm 2048 -> out of range
    drive(7'b0010011, 5'd1, 5'd1, 5'd0, 3'b000, 7'd0, 32'd2048);
    check("irange_err", 32'(err_valid), 32'd1);
    check("irange_code", 32'(err_code), 32'd2);
    check("irange_count", 32'(word_count), 32'd3);

    // branch both out of range and odd -> range wins
    drive(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'h00001001);
    check("bboth_code", 32'(err_code), 32'd2);
    check("bboth_we", 32'(mem_we), 32'd0);

    // lui opcode unsupported
    drive(7'b0110111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd0);
    check("badop_err", 32'(err_valid), 32'd1);
    check("badop_code", 32'(err_code), 32'd1);
    check("badop_count", 32'(word_count), 32'd3);

    idle();
    check("idle_we", 32'(mem_we), 32'd0);
    check("idle_err", 32'(err_valid), 32'd0);

    // add x3,x1,x2 -> 4th write, full with this strobe
    drive(7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'hDEADBEEF);
    check("add_we", 32'(mem_we), 32'd1);
    check("add_addr", 32'(mem_addr), 32'd12);
    check("add_wdata", mem_wdata, 32'h002081B3);
    check("add_count", 32'(word_count), 32'd4);
    check("add_full", 32'(full), 32'd1);
    check("full_ready", 32'(in_ready), 32'd0);

    // 5th request ignored while full
    drive(7'b0000011, 5'd5, 5'd2, 5'd0, 3'b010, 7'd0, 32'd8);
    check("ovf_we", 32'(mem_we), 32'd0);
    check("ovf_err", 32'(err_valid), 32'd0);
    check("ovf_count", 32'(word_count), 32'd4);
    check("ovf_addr", 32'(mem_addr), 32'd12);

    // clear with a valid request pending: clear wins
    clear = 1'b1;
    #1;
    check("clr_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    clear = 1'b0;
    check("clr_we", 32'(mem_we), 32'd0);
    check("clr_count", 32'(word_count), 32'd0);
    check("clr_full", 32'(full), 32'd0);

    drive(7'b0000011, 5'd5, 5'd2, 5'd0, 3'b010, 7'd0, 32'd8);
    check("postclr_addr", 32'(mem_addr), 32'd0);
    check("postclr_count", 32'(word_count), 32'd1);

    drive(7'b0100011, 5'd0, 5'd2, 5'd5, 3'b010, 7'd0, 32'hFFFFFFFC);
    check("prerst_we", 32'(mem_we), 32'd1);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_we", 32'(mem_we), 32'd0);
    check("midrst_addr", 32'(mem_addr), 32'd0);
    check("midrst_wdata", mem_wdata, 32'd0);
    check("midrst_count", 32'(word_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    drive(7'b0100011, 5'd0, 5'd2, 5'd5, 3'b010, 7'd0, 32'hFFFFFFFC);
    check("postrst_addr", 32'(mem_addr), 32'd0);
    check("postrst_wdata", mem_wdata, 32'hFE512E23);
    check("postrst_count", 32'(word_count), 32'd1);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
